// File: rtl/mux81_arb.sv
// Round-robin owner arbiter driving the select of a shared 8:1 mux.
// Optional owner timeout: define MUX81_ARB_PREEMPT_EN.
module mux81_arb #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy
);

   typedef enum logic {
      IDLE,
      OWN
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [2:0] ptr;
   logic [2:0] ptr_n;
   logic [2:0] win;
   logic [2:0] idx;
   logic [7:0] gnt_n;
   logic [2:0] sel_n;
   logic       rel;

   if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
      $error("mux81_arb: MAX_HOLD out of range");
   end

   // Scan downward so the lowest offset from ptr is kept last.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) win = idx;
      end
   end

`ifdef MUX81_ARB_PREEMPT_EN
   localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          expired;

   assign expired = (cnt == CMAX) && (|(req & ~gnt));
   assign rel     = !req[sel] || expired;

   always_comb begin
      cnt_n = cnt;
      if (state == IDLE) begin
         cnt_n = '0;
      end else if (!rel && cnt != CMAX) begin
         cnt_n = cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_n;
      end
   end
`else
   assign rel = !req[sel];
`endif

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      ptr_n   = ptr;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n = OWN;
               gnt_n   = 8'd1 << win;
               sel_n   = win;
            end
         end
         OWN: begin
            if (rel) begin
               state_n = IDLE;
               gnt_n   = '0;
               ptr_n   = sel + 3'd1;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         ptr   <= ptr_n;
      end
   end

   assign busy = |gnt;

endmodule

// File: tb/tb_mux81_arb.sv
// Scoreboard bench for mux81_arb: directed vectors, then a random
// request phase with protocol invariants.
module tb_mux81_arb;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;

   int n_chk;
   int n_fail;

   typedef struct {
      logic [7:0] g;
      logic [2:0] s;
   } exp_t;

   exp_t exp_q[$];
   bit   rnd_on;

   mux81_arb #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected entry per clock edge seen by a directed vector.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (gnt !== e.g || sel !== e.s || busy !== (|e.g)) begin
            n_fail++;
            $display("FAIL vec t=%0t: gnt=%h sel=%0d busy=%b, want gnt=%h sel=%0d busy=%b",
                     $time, gnt, sel, busy, e.g, e.s, |e.g);
         end
      end
   end

   // Random-phase invariants.
   logic [7:0] prev_gnt;
   logic [2:0] prev_sel;
   logic       prev_busy;
   int         waits[8];

   always @(posedge clk) begin
      bit ok;
      int worst;
      #1;
      if (rnd_on) begin
         worst = 0;
         if (busy && !prev_busy) begin
            for (int i = 0; i < 8; i++) begin
               if (gnt[i]) waits[i] = 0;
               else if (req[i]) waits[i]++;
            end
         end
         for (int i = 0; i < 8; i++) begin
            if (!req[i]) waits[i] = 0;
            if (waits[i] > worst) worst = waits[i];
         end
         ok = ($countones(gnt) <= 1) && (busy == (|gnt));
         if (busy && !gnt[sel]) ok = 1'b0;
         if (busy && prev_busy && (sel != prev_sel || gnt != prev_gnt))
            ok = 1'b0;
         if (worst > 8) ok = 1'b0;
         n_chk++;
         if (!ok) begin
            n_fail++;
            $display("FAIL rnd t=%0t: gnt=%h sel=%0d busy=%b prev=%h/%0d worst_wait=%0d, want onehot owner stable and wait<=8",
                     $time, gnt, sel, busy, prev_gnt, prev_sel, worst);
         end
      end
      prev_gnt  = gnt;
      prev_sel  = sel;
      prev_busy = busy;
   end

   task automatic cyc(input logic [7:0] r, input logic [7:0] g,
                      input logic [2:0] s);
      exp_t e;
      @(negedge clk);
      req = r;
      e.g = g;
      e.s = s;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [11:0] act,
                      input logic [11:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, want);
      end
   endtask

   task automatic drain();
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      n_chk  = 0;
      n_fail = 0;
      rnd_on = 1'b0;
      rst_n  = 1'b0;
      req    = '0;
      for (int i = 0; i < 8; i++) waits[i] = 0;
      repeat (2) @(negedge clk);
      chk("reset", {gnt, sel, busy}, 12'h0);
      rst_n = 1'b1;

      cyc(8'h81, 8'h01, 3'd0);
      cyc(8'h80, 8'h00, 3'd0);
      cyc(8'h80, 8'h80, 3'd7);
      cyc(8'h80, 8'h80, 3'd7);
      cyc(8'h01, 8'h00, 3'd7);
      cyc(8'h01, 8'h01, 3'd0);
      cyc(8'h00, 8'h00, 3'd0);
      cyc(8'h00, 8'h00, 3'd0);
      drain();

      // Idle reset pulse brings ptr back to 0 for the rotation run.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         b = 8'd1 << (k % 8);
         cyc(8'hFF, b, 3'(k % 8));
         cyc(8'hFF, b, 3'(k % 8));
         cyc(8'hFF, b, 3'(k % 8));
         cyc(8'hFF & ~b, 8'h00, 3'(k % 8));
      end
      cyc(8'h00, 8'h00, 3'd0);
      drain();

      cyc(8'h10, 8'h10, 3'd4);
      cyc(8'h10, 8'h10, 3'd4);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk("async_rst", {gnt, sel, busy}, 12'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(8'h10, 8'h10, 3'd4);
      cyc(8'h00, 8'h00, 3'd4);

      cyc(8'h04, 8'h04, 3'd2);
      repeat (6) cyc(8'h04, 8'h04, 3'd2);
      cyc(8'h00, 8'h00, 3'd2);
      cyc(8'h04, 8'h04, 3'd2);
      repeat (3) cyc(8'h24, 8'h04, 3'd2);
`ifdef MUX81_ARB_PREEMPT_EN
      cyc(8'h24, 8'h00, 3'd2);
      cyc(8'h24, 8'h20, 3'd5);
      cyc(8'h04, 8'h00, 3'd5);
      cyc(8'h04, 8'h04, 3'd2);
      cyc(8'h00, 8'h00, 3'd2);
`else
      repeat (100) cyc(8'h24, 8'h04, 3'd2);
      cyc(8'h20, 8'h00, 3'd2);
      cyc(8'h20, 8'h20, 3'd5);
      cyc(8'h00, 8'h00, 3'd5);
`endif
      drain();

      rnd_on = 1'b1;
      repeat (10000) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            if (gnt[i]) begin
               if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
            end
         end
      end
      @(negedge clk);
      rnd_on = 1'b0;
      req    = '0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux81_arb.md
Name: mux81_arb

Overview:
- Round-robin arbiter and select sequencer that shares one 8:1 mux path (3-bit select, 8 data inputs) among 8 requesters.
- Decides which requester owns the mux and drives the registered select lines and a one-hot grant.
- Every change of owner passes through one dead cycle (no grant), so the mux select always breaks before it makes.
- Sits between the requesting blocks and the mux instance; the mux's s input connects directly to sel.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant while others wait (legal range 2..256; used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request per requester; held high for as long as the requester needs the mux.
- gnt  output  8  one-hot grant, registered; all zeros when no owner.
- sel  output  3  mux select, registered; equals the index of the granted requester.
- busy  output  1  high while any grant is asserted (equals OR of gnt).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - gnt=0, sel=0, busy=0.
  - Round-robin pointer ptr=0, hold counter cnt=0, state=IDLE.
- States:
  - IDLE: gnt=0; sel keeps its last value.
  - OWN: exactly one gnt bit set.
- IDLE -> OWN:
  - Triggered when req != 0 at a rising edge.
  - Winner: first set bit found searching indices ptr, ptr+1, ... ptr+7 (mod 8).
  - gnt[winner], sel=winner and busy=1 appear at that same edge (1-cycle latency from req to gnt); cnt=0.
- OWN, release:
  - If req[owner]=0 at an edge, next state is IDLE and gnt=0.
  - ptr = owner+1 mod 8 (wraps 7 -> 0).
- OWN, otherwise: owner retains; cnt increments and saturates at MAX_HOLD-1.
- Requests from non-owners never alter gnt or sel while in OWN.
- Minimum gap between two different grants is exactly one cycle with gnt=0. Back-to-back grants to the same requester also pass through IDLE.
- Release and a new request on the same edge: release wins; the new request is considered in the following IDLE cycle.
- req deasserted by a requester before it is granted: nothing is recorded; a requester must hold req until granted.
- sel only changes on the IDLE -> OWN transition, so sel is stable for the entire ownership.
- Invariants: popcount(gnt) <= 1; gnt != 0 implies gnt[sel] = 1.

Optional Feature:
- Macro: MUX81_ARB_PREEMPT_EN.
- Defined:
  - In OWN, when cnt == MAX_HOLD-1 and (req & ~gnt) != 0, the owner is preempted.
  - Next state IDLE, gnt=0, ptr = owner+1 mod 8.
  - The preempted requester may re-request and competes normally.
  - If no other request is pending at cnt == MAX_HOLD-1, the owner keeps the grant and cnt stays saturated.
- Not defined: no timeout; the owner keeps the grant until it drops req; cnt logic is removed.

Test Plan:
- Reset then req=8'b1000_0001 -> next edge gnt=8'h01, sel=0, busy=1.
- Drop req[0] while req[7] stays high -> one cycle gnt=0, then gnt=8'h80, sel=7. Drop req[7] with req=8'h01 -> gnt=8'h01 after the gap (pointer wraps 7 -> 0).
- req=8'hFF held and each owner releases after 3 cycles (re-raising req one cycle later) -> grant order 0,1,2,...,7,0, with exactly one gnt=0 cycle between owners.
- Assert rst_n=0 mid-grant (gnt=8'h10) between clock edges -> gnt=0, sel=0, busy=0 immediately. After release, req=8'h10 -> gnt=8'h10 (ptr was 0).
- With MUX81_ARB_PREEMPT_EN and MAX_HOLD=4: req[2] holds and req[5] is raised -> gnt=8'h04 for 4 cycles, 1 dead cycle, then gnt=8'h20. Without the macro, gnt=8'h04 persists for 100 cycles.
- Random req for 10k cycles with checkers on: popcount(gnt) <= 1, gnt[sel] whenever busy, sel never changes while busy, and no requester held continuously waits more than 8 ownerships.
